// File: rtl/alu_pipe.sv
// Pipelined RV64I/RV32I integer ALU with an elastic valid/ready pipeline, tag pass-through and flush.
// The first register captures the combinational result; later registers are pure delay.
module alu_pipe #(
  parameter int XLEN   = 64,
  parameter int STAGES = 2,
  parameter int TAG_W  = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic             in_word,
  input  logic [XLEN-1:0]  in_op1,
  input  logic [XLEN-1:0]  in_op2,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal,
  output logic             busy
);

  localparam int SHW = $clog2(XLEN);

  logic [SHW-1:0]  shamt;
  logic [31:0]     imm32;
  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] base_res;
  logic [XLEN-1:0] alu_res;
  logic            alu_illegal;

  assign shamt = in_op2[SHW-1:0];
  assign imm32 = {in_op2[19:0], 12'h000};
  assign imm   = XLEN'($signed(imm32));

  always_comb begin
    base_res    = '0;
    alu_illegal = 1'b0;
    case (in_op)
      4'd0:    base_res = in_op1 + in_op2;
      4'd1:    base_res = in_op1 - in_op2;
      4'd2:    base_res = in_op1 << shamt;
      4'd3:    base_res = {{(XLEN-1){1'b0}}, $signed(in_op1) < $signed(in_op2)};
      4'd4:    base_res = {{(XLEN-1){1'b0}}, in_op1 < in_op2};
      4'd5:    base_res = in_op1 ^ in_op2;
      4'd6:    base_res = in_op1 >> shamt;
      4'd7:    base_res = $signed(in_op1) >>> shamt;
      4'd8:    base_res = in_op1 | in_op2;
      4'd9:    base_res = in_op1 & in_op2;
      4'd10:   base_res = imm;
      4'd11:   base_res = in_op1 + imm;
      default: alu_illegal = 1'b1;
    endcase
  end

  // Word variants exist only on a 64-bit datapath; a 32-bit build ignores in_word.
  generate
    if (XLEN == 64) begin : g_word
      logic [31:0] w_res;
      logic        w_sel;

      always_comb begin
        w_res = '0;
        case (in_op)
          4'd0:    w_res = in_op1[31:0] + in_op2[31:0];
          4'd1:    w_res = in_op1[31:0] - in_op2[31:0];
          4'd2:    w_res = in_op1[31:0] << in_op2[4:0];
          4'd6:    w_res = in_op1[31:0] >> in_op2[4:0];
          4'd7:    w_res = $signed(in_op1[31:0]) >>> in_op2[4:0];
          default: w_res = '0;
        endcase
      end

      assign w_sel   = in_word && (in_op == 4'd0 || in_op == 4'd1 || in_op == 4'd2 ||
                                   in_op == 4'd6 || in_op == 4'd7);
      assign alu_res = w_sel ? {{32{w_res[31]}}, w_res} : base_res;
    end else begin : g_noword
      logic unused_word;
      assign unused_word = in_word;
      assign alu_res     = base_res;
    end
  endgenerate

  logic [STAGES-1:0] valid_q, valid_d, en, src_valid;
  logic [XLEN-1:0]   res_q [STAGES];
  logic [XLEN-1:0]   res_d [STAGES];
  logic [XLEN-1:0]   src_res [STAGES];
  logic [TAG_W-1:0]  tag_q [STAGES];
  logic [TAG_W-1:0]  tag_d [STAGES];
  logic [TAG_W-1:0]  src_tag [STAGES];
  logic [STAGES-1:0] ill_q, ill_d, src_ill;

  assign in_ready = !flush && en[0];

  // A stage may load when some stage at or after it has a hole, or the output drains.
  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      assign en[gi] = out_ready || !(&valid_q[STAGES-1:gi]);

      if (gi == 0) begin : g_first
        assign src_valid[gi] = in_valid && in_ready;
        assign src_res[gi]   = alu_illegal ? '0 : alu_res;
        assign src_tag[gi]   = in_tag;
        assign src_ill[gi]   = alu_illegal;
      end else begin : g_delay
        assign src_valid[gi] = valid_q[gi-1];
        assign src_res[gi]   = res_q[gi-1];
        assign src_tag[gi]   = tag_q[gi-1];
        assign src_ill[gi]   = ill_q[gi-1];
      end

      assign valid_d[gi] = flush ? 1'b0 : (en[gi] ? src_valid[gi] : valid_q[gi]);
      assign res_d[gi]   = en[gi] ? src_res[gi] : res_q[gi];
      assign tag_d[gi]   = en[gi] ? src_tag[gi] : tag_q[gi];
      assign ill_d[gi]   = en[gi] ? src_ill[gi] : ill_q[gi];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      ill_q   <= '0;
      for (int k = 0; k < STAGES; k++) begin
        res_q[k] <= '0;
        tag_q[k] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      ill_q   <= ill_d;
      for (int k = 0; k < STAGES; k++) begin
        res_q[k] <= res_d[k];
        tag_q[k] <= tag_d[k];
      end
    end
  end

  assign out_valid   = valid_q[STAGES-1];
  assign out_result  = res_q[STAGES-1];
  assign out_tag     = tag_q[STAGES-1];
  assign out_illegal = ill_q[STAGES-1];
  assign busy        = |valid_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe: a 64-bit/2-stage unit plus 32-bit units with 1 and 3 stages
// sharing the same input bus.
module tb_alu_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, flush, in_valid, in_word, out_ready;
  logic [3:0]  in_op;
  logic [63:0] in_op1, in_op2;
  logic [4:0]  in_tag;

  logic        in_ready, out_valid, out_illegal, busy;
  logic [63:0] out_result;
  logic [4:0]  out_tag;

  logic        s1_in_ready, s1_out_valid, s1_ill, s1_busy;
  logic [31:0] s1_result;
  logic [4:0]  s1_tag;
  logic        s3_in_ready, s3_out_valid, s3_ill, s3_busy;
  logic [31:0] s3_result;
  logic [4:0]  s3_tag;

  alu_pipe #(.XLEN(64), .STAGES(2), .TAG_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_word(in_word), .in_op1(in_op1), .in_op2(in_op2), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_tag(out_tag), .out_illegal(out_illegal), .busy(busy)
  );

  alu_pipe #(.XLEN(32), .STAGES(1), .TAG_W(5)) dut_s1 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(s1_in_ready),
    .in_op(in_op), .in_word(in_word), .in_op1(in_op1[31:0]), .in_op2(in_op2[31:0]), .in_tag(in_tag),
    .out_valid(s1_out_valid), .out_ready(out_ready), .out_result(s1_result),
    .out_tag(s1_tag), .out_illegal(s1_ill), .busy(s1_busy)
  );

  alu_pipe #(.XLEN(32), .STAGES(3), .TAG_W(5)) dut_s3 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(s3_in_ready),
    .in_op(in_op), .in_word(in_word), .in_op1(in_op1[31:0]), .in_op2(in_op2[31:0]), .in_tag(in_tag),
    .out_valid(s3_out_valid), .out_ready(out_ready), .out_result(s3_result),
    .out_tag(s3_tag), .out_illegal(s3_ill), .busy(s3_busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  typedef struct {
    logic [3:0]  op;
    logic        word;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
    logic        ill;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic [3:0] op, input logic word, input logic [63:0] a,
                         input logic [63:0] b, input logic [63:0] exp, input logic ill);
    vec_t v;
    v.op = op; v.word = word; v.a = a; v.b = b; v.exp = exp; v.ill = ill;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic [3:0] op, input logic word, input logic [63:0] a,
                       input logic [63:0] b, input logic [4:0] tag);
    in_valid = 1'b1; in_op = op; in_word = word; in_op1 = a; in_op2 = b; in_tag = tag;
  endtask

  task automatic sweep(input logic [3:0] op, input logic word, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input logic ill,
                       input logic [4:0] tag);
    int lat1, lat3;
    logic [31:0] r1, r3;
    logic i1, i3;
    logic [4:0] t1, t3;
    lat1 = 0; lat3 = 0; r1 = '0; r3 = '0; i1 = 0; i3 = 0; t1 = '0; t3 = '0;
    @(posedge clk); #1;
    drive(op, word, {32'hDEAD_BEEF, a}, {32'h0000_0001, b}, tag);
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      if (c == 1) in_valid = 1'b0;
      if (s1_out_valid && lat1 == 0) begin lat1 = c; r1 = s1_result; i1 = s1_ill; t1 = s1_tag; end
      if (s3_out_valid && lat3 == 0) begin lat3 = c; r3 = s3_result; i3 = s3_ill; t3 = s3_tag; end
    end
    chk($sformatf("x32 op%0d s1 latency", op), 64'(lat1), 64'd1);
    chk($sformatf("x32 op%0d s3 latency", op), 64'(lat3), 64'd3);
    chk($sformatf("x32 op%0d s1 result", op), 64'(r1), 64'(exp));
    chk($sformatf("x32 op%0d s3 result", op), 64'(r3), 64'(exp));
    chk($sformatf("x32 op%0d illegal", op), {62'd0, i1, i3}, {62'd0, ill, ill});
    chk($sformatf("x32 op%0d tags", op), {54'd0, t1, t3}, {54'd0, tag, tag});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int lat, idx, rx, cyc, cnt;
    logic got, r, v;

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_word = 1'b0; out_ready = 1'b1;
    in_op = '0; in_op1 = '0; in_op2 = '0; in_tag = '0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    #1;
    chk("reset out_valid", {63'd0, out_valid}, 64'd0);
    chk("reset busy", {63'd0, busy}, 64'd0);
    chk("reset in_ready", {63'd0, in_ready}, 64'd1);
    chk("reset out_result", out_result, 64'd0);
    chk("reset tag/illegal", {58'd0, out_tag, out_illegal}, 64'd0);

    add_vec(4'd0, 0, 64'd5, 64'd7, 64'd12, 0);
    add_vec(4'd1, 0, 64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    add_vec(4'd3, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd1, 0);
    add_vec(4'd4, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 0);
    add_vec(4'd3, 0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 0);
    add_vec(4'd4, 0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 0);
    add_vec(4'd0, 1, 64'h7FFF_FFFF, 64'd1, 64'hFFFF_FFFF_8000_0000, 0);
    add_vec(4'd7, 1, 64'h8000_0000, 64'd4, 64'hFFFF_FFFF_F800_0000, 0);
    add_vec(4'd1, 1, 64'h1_0000_0000, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    add_vec(4'd6, 1, 64'hFFFF_FFFF_8000_0000, 64'd4, 64'h0000_0000_0800_0000, 0);
    add_vec(4'd2, 1, 64'd1, 64'd31, 64'hFFFF_FFFF_8000_0000, 0);
    add_vec(4'd2, 0, 64'd3, 64'd65, 64'd6, 0);
    add_vec(4'd10, 0, 64'd0, 64'h8_0000, 64'hFFFF_FFFF_8000_0000, 0);
    add_vec(4'd11, 0, 64'h1000, 64'd1, 64'h2000, 0);
    add_vec(4'd5, 1, 64'hFFFF_FFFF_0000_0000, 64'd0, 64'hFFFF_FFFF_0000_0000, 0);
    add_vec(4'd5, 0, 64'hF0F0, 64'hFF00, 64'h0FF0, 0);
    add_vec(4'd6, 0, 64'h8000_0000_0000_0000, 64'd4, 64'h0800_0000_0000_0000, 0);
    add_vec(4'd7, 0, 64'h8000_0000_0000_0000, 64'd4, 64'hF800_0000_0000_0000, 0);
    add_vec(4'd8, 0, 64'hF0, 64'h0F, 64'hFF, 0);
    add_vec(4'd9, 0, 64'hF0, 64'h3C, 64'h30, 0);
    add_vec(4'd13, 0, 64'd5, 64'd7, 64'd0, 1);

    foreach (vecs[i]) begin
      @(posedge clk); #1;
      drive(vecs[i].op, vecs[i].word, vecs[i].a, vecs[i].b, 5'(i + 1));
      chk($sformatf("vec%0d in_ready", i), {63'd0, in_ready}, 64'd1);
      lat = 0; got = 1'b0;
      for (int c = 1; c <= 8 && !got; c++) begin
        @(posedge clk); #1;
        if (c == 1) in_valid = 1'b0;
        if (out_valid) begin got = 1'b1; lat = c; end
      end
      chk($sformatf("vec%0d op%0d latency", i, vecs[i].op), 64'(lat), 64'd2);
      chk($sformatf("vec%0d op%0d result", i, vecs[i].op), out_result, vecs[i].exp);
      chk($sformatf("vec%0d tag/illegal", i), {58'd0, out_tag, out_illegal},
          {58'd0, 5'(i + 1), vecs[i].ill});
    end

    // Backpressure: 5 ADDs while the consumer stalls for the first 4 cycles.
    @(posedge clk); #1;
    idx = 1; rx = 1; cyc = 0;
    while ((idx <= 5 || rx <= 5) && cyc < 40) begin
      out_ready = (cyc >= 4);
      in_valid  = (idx <= 5);
      in_op = 4'd0; in_word = 1'b0; in_op1 = 64'(idx * 10); in_op2 = 64'(idx); in_tag = 5'(idx);
      @(negedge clk);
      if (cyc == 2 || cyc == 3) begin
        chk($sformatf("bp c%0d in_ready low", cyc), {63'd0, in_ready}, 64'd0);
        chk($sformatf("bp c%0d held valid/tag", cyc), {58'd0, out_valid, out_tag}, {58'd0, 1'b1, 5'd1});
        chk($sformatf("bp c%0d held result", cyc), out_result, 64'd11);
      end
      if (out_valid && out_ready) begin
        chk($sformatf("bp rx%0d tag", rx), 64'(out_tag), 64'(rx));
        chk($sformatf("bp rx%0d result", rx), out_result, 64'(rx * 11));
        rx++;
      end
      r = in_ready; v = in_valid;
      @(posedge clk); #1;
      if (r && v) idx++;
      cyc++;
    end
    in_valid = 1'b0;
    chk("bp delivered count", 64'(rx - 1), 64'd5);
    cnt = 0;
    repeat (4) begin @(posedge clk); #1; if (out_valid) cnt++; end
    chk("bp no duplicates", 64'(cnt), 64'd0);

    // Flush with tags 1,2 in flight and tag 3 offered in the flush cycle.
    out_ready = 1'b1;
    @(posedge clk); #1; drive(4'd0, 0, 64'd1, 64'd0, 5'd1);
    @(posedge clk); #1; drive(4'd0, 0, 64'd2, 64'd0, 5'd2);
    @(posedge clk); #1; drive(4'd0, 0, 64'd3, 64'd0, 5'd3);
    flush = 1'b1;
    #1;
    chk("flush in_ready low", {63'd0, in_ready}, 64'd0);
    chk("flush-cycle delivery tag1", {58'd0, out_valid, out_tag}, {58'd0, 1'b1, 5'd1});
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    chk("post-flush busy/out_valid", {62'd0, busy, out_valid}, 64'd0);
    cnt = 0;
    repeat (5) begin @(posedge clk); #1; if (out_valid) cnt++; end
    chk("flush nothing emitted", 64'(cnt), 64'd0);

    // Asynchronous reset with two entries held in flight.
    out_ready = 1'b0;
    @(posedge clk); #1; drive(4'd0, 0, 64'd100, 64'd1, 5'd7);
    @(posedge clk); #1; drive(4'd0, 0, 64'd200, 64'd2, 5'd8);
    @(posedge clk); #1; in_valid = 1'b0;
    chk("pre-reset head", {out_valid, busy, out_tag, out_result[56:0]},
        {1'b1, 1'b1, 5'd7, 57'd101});
    #3 rst_n = 1'b0;
    #1;
    chk("async reset valid/busy", {62'd0, out_valid, busy}, 64'd0);
    chk("async reset result", out_result, 64'd0);
    chk("async reset tag/illegal", {58'd0, out_tag, out_illegal}, 64'd0);
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("post-reset in_ready", {63'd0, in_ready}, 64'd1);
    cnt = 0;
    repeat (5) begin @(posedge clk); #1; if (out_valid || s1_out_valid || s3_out_valid) cnt++; end
    chk("post-reset nothing emitted", 64'(cnt), 64'd0);

    // 32-bit builds with 1 and 3 stages; in_word must have no effect.
    sweep(4'd0, 1, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 0, 5'd9);
    sweep(4'd1, 1, 32'd0, 32'd1, 32'hFFFF_FFFF, 0, 5'd10);
    sweep(4'd2, 0, 32'd1, 32'd33, 32'd2, 0, 5'd11);
    sweep(4'd6, 1, 32'h8000_0000, 32'd36, 32'h0800_0000, 0, 5'd12);
    sweep(4'd10, 0, 32'd0, 32'h8_0000, 32'h8000_0000, 0, 5'd13);
    sweep(4'd3, 0, 32'hFFFF_FFFF, 32'd1, 32'd1, 0, 5'd14);
    sweep(4'd13, 0, 32'd5, 32'd7, 32'd0, 1, 5'd15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, pipelined integer execution unit for the RV64I base ALU operations, including the RV64 word (W) variants.
- Sits in stage 3 between the issue logic and writeback.
- Accepts one operation per cycle over a valid/ready handshake, carries a destination tag alongside the operation, and supports flushing all in-flight work on a redirect.

Parameters:
- XLEN, 64, datapath width. Legal values are 32 and 64. Word ops are honoured only when XLEN=64.
- STAGES, 2, number of pipeline registers from input to output. Legal range 1..3. Latency is STAGES cycles.
- TAG_W, 5, width of the pass-through destination tag.

Ports:
- clk  in  1  clock. All state updates on the rising edge.
- rst_n  in  1  asynchronous reset, active-low.
- flush  in  1  kills every in-flight operation.
- in_valid  in  1  an operation is offered on the input.
- in_ready  out  1  the unit can accept an operation this cycle.
- in_op  in  4  operation code; see Behaviour.
- in_word  in  1  selects 32-bit word variant (ADDW, SUBW, SLLW, SRLW, SRAW).
- in_op1  in  XLEN  rs1 value, or pc for AUIPC.
- in_op2  in  XLEN  rs2 value or immediate.
- in_tag  in  TAG_W  destination tag.
- out_valid  out  1  a result is presented on the output.
- out_ready  in  1  the consumer accepts the result.
- out_result  out  XLEN  computed result.
- out_tag  out  TAG_W  tag of the presented result.
- out_illegal  out  1  the presented op code was unsupported.
- busy  out  1  at least one pipeline stage holds a valid entry.

Behaviour:
- Op codes: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 LUI, 11 AUIPC. Codes 12..15 are illegal.
- Shift amount:
  - Non-word ops use op2[log2(XLEN)-1:0].
  - Word ops use op2[4:0].
- SLT and SLTU produce 0 or 1, zero-extended to XLEN. SLT is a signed compare; SLTU is unsigned.
- LUI: imm = sign-extend({op2[19:0], 12'b0}) to XLEN; result = imm.
- AUIPC: result = op1 + imm, computed modulo 2^XLEN.
- Word mode (XLEN=64 and in_word=1):
  - Applies to ops 0, 1, 2, 6 and 7.
  - The op is computed on op1[31:0] and op2[31:0].
  - The 32-bit result is sign-extended to 64 bits.
  - in_word is ignored for all other ops, and ignored entirely when XLEN=32.
- Illegal op: result is 0, out_illegal=1, and the tag passes through normally.
- Pipeline structure:
  - Combinational compute feeds the first register.
  - Remaining registers are pure delay.
  - Each stage has its own valid bit.
- Advance rules:
  - Stage k loads when it is empty or when it is being drained this cycle.
  - The last stage drains when out_valid && out_ready.
  - in_ready = !flush && (stage 0 empty || stage 0 advancing).
  - This gives an elastic pipeline: bubbles collapse, and throughput is 1 per cycle with out_ready held high.
- A transfer happens on in_valid && in_ready at a clock edge.
- A held output (out_valid=1, out_ready=0) keeps out_result, out_tag and out_illegal stable until accepted.
- Latency:
  - out_valid rises exactly STAGES cycles after acceptance when no backpressure is applied.
  - Results emerge in acceptance order.
- Flush:
  - All valid bits clear at the next edge.
  - in_ready is 0 during the flush cycle, so in_valid that cycle is not accepted.
  - An output handshake in the same cycle as flush still completes; that result counts as delivered.
  - Data registers need not clear on flush.
- busy = OR of all stage valid bits.
- Reset (rst_n low, asynchronous):
  - All valid bits, out_result, out_tag and out_illegal go to 0.
  - Hence out_valid=0, busy=0 and in_ready=1 after release (absent flush).
  - Reset mid-operation discards all in-flight entries.

Test Plan:
- Basic ops, XLEN=64, STAGES=2, out_ready=1:
  - ADD 5+7 -> 12, with out_valid exactly 2 cycles after acceptance and tag preserved.
  - SUB 0-1 -> 0xFFFF_FFFF_FFFF_FFFF.
  - SLT(-1,1) -> 1; SLTU(-1,1) -> 0.
- Word and immediate ops:
  - ADDW 0x7FFF_FFFF+1 -> 0xFFFF_FFFF_8000_0000.
  - SRAW 0x8000_0000>>4 -> 0xFFFF_FFFF_F800_0000.
  - SLL with op2=65 shifts by 1.
  - LUI op2=0x80000 -> 0xFFFF_FFFF_8000_0000.
  - AUIPC op1=0x1000, op2=1 -> 0x2000.
- Backpressure:
  - Stream 5 ADDs with tags 1..5 while holding out_ready=0 for 4 cycles.
  - in_ready must drop once both stages are full.
  - Output stays stable while held.
  - All 5 results are delivered in order with no loss or duplication.
- Flush:
  - Accept tags 1 and 2, then assert flush with in_valid=1 carrying tag 3.
  - Next cycle: busy=0 and out_valid=0.
  - Tag 3 is never produced.
- Reset mid-stream:
  - Drop rst_n asynchronously between edges with 2 entries in flight.
  - Outputs go to 0 immediately.
  - After release, in_ready=1 and nothing is emitted.
- Parameter sweep:
  - XLEN=32 with STAGES=1 and STAGES=3.
  - Latency equals STAGES.
  - in_word is ignored.
  - Op code 13 -> result 0, out_illegal=1.
